// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// ID-stage hazard detector for the five-stage pipeline. The decoded source
// registers are compared against pending writes in EX and MEM, and a stall is
// produced for load-use hazards and for branches/jump-registers whose operands
// are consumed in ID. Stalls of two or more cycles are held by a small FSM.
// A saturating counter records the number of stalled cycles for debug.
//
// State table:
//   IDLE  | evaluating hazards combinationally; single-cycle stalls re-evaluate
//   STALL | holding a multi-cycle stall; inputs ignored until rem_q reaches 0
//
// Ports:
//   i_clock, i_reset       clock (rising edge), async active-low reset
//   i_valid_id             ID holds a real instruction
//   i_rs/i_rt, i_use_rs/rt ID source registers and their read enables
//   i_jmp_branch           ID instruction is a branch / jump-register
//   i_ex_*                 EX stage regwrite, load flag, destination
//   i_mem_*                MEM stage load flag, destination
//   i_flush                abort any stall
//   o_stall, o_hazard      stall request (identical)
//   o_stall_cycles         saturating count of stalled cycles (1-cycle lag)
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int NB_REG_ADDR  = 5,
  parameter int NB_STALL_CNT = 2,
  parameter int NB_PERF_CNT  = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid_id,
  input  logic [NB_REG_ADDR-1:0]  i_rs,
  input  logic [NB_REG_ADDR-1:0]  i_rt,
  input  logic                    i_use_rs,
  input  logic                    i_use_rt,
  input  logic                    i_jmp_branch,
  input  logic                    i_ex_regwrite,
  input  logic                    i_ex_mem_read,
  input  logic [NB_REG_ADDR-1:0]  i_ex_rd,
  input  logic                    i_mem_mem_read,
  input  logic [NB_REG_ADDR-1:0]  i_mem_rd,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic                    o_hazard,
  output logic [NB_PERF_CNT-1:0]  o_stall_cycles
);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                   state_q, state_d;
  logic [NB_STALL_CNT-1:0]  rem_q, rem_d;
  logic [NB_PERF_CNT-1:0]   perf_cnt_q, perf_cnt_d;
  logic [NB_STALL_CNT-1:0]  need;
  logic                     ex_match, mem_match;
  logic                     stall;

  // Register 0 is hard-wired, so a write to it can never create a hazard.
  assign ex_match  = (i_ex_rd != '0) &
                     ((i_use_rs & (i_rs == i_ex_rd)) | (i_use_rt & (i_rt == i_ex_rd)));
  assign mem_match = (i_mem_rd != '0) &
                     ((i_use_rs & (i_rs == i_mem_rd)) | (i_use_rt & (i_rt == i_mem_rd)));

  // Checks ordered from largest to smallest need, so the first hit is the max.
  // A MEM non-load is covered by forwarding and never stalls.
  always_comb begin
    need = '0;
    if (i_valid_id) begin
      if (i_ex_mem_read && ex_match) begin
        need = i_jmp_branch ? NB_STALL_CNT'(2) : NB_STALL_CNT'(1);
      end else if (i_jmp_branch &&
                   ((i_ex_regwrite && ex_match) || (i_mem_mem_read && mem_match))) begin
        need = NB_STALL_CNT'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    if (i_flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stall = (need != '0);
          // First stall cycle is this one; rem counts the extra cycles after
          // the next, so rem == 0 in STALL means one more cycle then IDLE.
          if (need >= NB_STALL_CNT'(2)) begin
            state_d = STALL;
            rem_d   = need - NB_STALL_CNT'(2);
          end
        end
        STALL: begin
          stall = 1'b1;
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - NB_STALL_CNT'(1);
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (stall && (perf_cnt_q != '1)) perf_cnt_d = perf_cnt_q + NB_PERF_CNT'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      perf_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign o_stall        = stall;
  assign o_hazard       = stall;
  assign o_stall_cycles = perf_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid_id, i_use_rs, i_use_rt, i_jmp_branch;
  logic [4:0]  i_rs, i_rt, i_ex_rd, i_mem_rd;
  logic        i_ex_regwrite, i_ex_mem_read, i_mem_mem_read, i_flush;
  logic        o_stall, o_hazard, s_stall, s_hazard;
  logic [31:0] o_stall_cycles;
  logic [3:0]  s_stall_cycles;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  int exp_small = 0;

  always #5 i_clock = ~i_clock;

  hazard_stall_unit #(.NB_REG_ADDR(5), .NB_STALL_CNT(2), .NB_PERF_CNT(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid_id(i_valid_id),
    .i_rs(i_rs), .i_rt(i_rt), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_jmp_branch(i_jmp_branch), .i_ex_regwrite(i_ex_regwrite),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_rd(i_mem_rd), .i_flush(i_flush),
    .o_stall(o_stall), .o_hazard(o_hazard), .o_stall_cycles(o_stall_cycles)
  );

  hazard_stall_unit #(.NB_REG_ADDR(5), .NB_STALL_CNT(2), .NB_PERF_CNT(4)) dut_small (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid_id(i_valid_id),
    .i_rs(i_rs), .i_rt(i_rt), .i_use_rs(i_use_rs), .i_use_rt(i_use_rt),
    .i_jmp_branch(i_jmp_branch), .i_ex_regwrite(i_ex_regwrite),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_rd(i_mem_rd), .i_flush(i_flush),
    .o_stall(s_stall), .o_hazard(s_hazard), .o_stall_cycles(s_stall_cycles)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       jmp;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       flush;
    logic       exp_stall;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_valid_id     = v.valid;
    i_rs           = v.rs;
    i_rt           = v.rt;
    i_use_rs       = v.use_rs;
    i_use_rt       = v.use_rt;
    i_jmp_branch   = v.jmp;
    i_ex_regwrite  = v.ex_rw;
    i_ex_mem_read  = v.ex_mr;
    i_ex_rd        = v.ex_rd;
    i_mem_mem_read = v.mem_mr;
    i_mem_rd       = v.mem_rd;
    i_flush        = v.flush;
  endtask

  task automatic set_quiet();
    vec_t q;
    q = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    drive(q);
  endtask

  // Model of the counters: one increment per stalled cycle, small one saturates.
  task automatic tick();
    exp_cnt++;
    if (exp_small < 15) exp_small++;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    chk({name, "_stall"},  {31'd0, o_stall},  {31'd0, exp});
    chk({name, "_hazard"}, {31'd0, o_hazard}, {31'd0, exp});
  endtask

  task automatic chk_cnt(input string name);
    chk({name, "_cnt"},       o_stall_cycles,          exp_cnt);
    chk({name, "_cnt_small"}, {28'd0, s_stall_cycles}, exp_small);
  endtask

  vec_t br_load;
  vec_t load_use;

  initial begin
    //            valid  rs     rt     urs   urt   jmp   exrw  exmr  exrd   memmr memrd  flush exp
    vec[0]  = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b1}; // load-use
    vec[1]  = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0}; // r0
    vec[2]  = '{1'b1, 5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 5'd0,  1'b0, 1'b0}; // rt unused
    vec[3]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0,  1'b0, 1'b1}; // jr after ALU
    vec[4]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 1'b1}; // jr after MEM load
    vec[5]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd9,  1'b0, 1'b0}; // add vs MEM load
    vec[6]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9,  1'b0, 5'd0,  1'b0, 1'b0}; // add vs EX ALU
    vec[7]  = '{1'b0, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b0}; // bubble
    vec[8]  = '{1'b1, 5'd0,  5'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4,  1'b0, 5'd0,  1'b0, 1'b1}; // load-use on rt
    vec[9]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0,  1'b0, 5'd9,  1'b0, 1'b0}; // jr vs MEM ALU
    vec[10] = '{1'b1, 5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  1'b0, 5'd0,  1'b1, 1'b0}; // flush wins
    vec[11] = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9,  1'b0, 5'd0,  1'b0, 1'b0}; // no regwrite
    vec[12] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0}; // jr r0 vs r0
    br_load  = '{1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1};
    load_use = vec[0];

    i_reset = 1'b0;
    set_quiet();
    #12;
    chk_stall("reset", 1'b0);
    chk_cnt("reset");
    @(negedge i_clock);
    i_reset = 1'b1;

    // Single-cycle patterns applied from IDLE.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge i_clock);
      drive(vec[i]);
      #1;
      chk_stall($sformatf("vec%0d", i), vec[i].exp_stall);
      chk_cnt($sformatf("vec%0d", i));
      if (vec[i].exp_stall) tick();
    end

    // Branch after load: two stall cycles, second one independent of inputs.
    @(negedge i_clock);
    drive(br_load);
    #1 chk_stall("brload_c1", 1'b1);
    chk_cnt("brload_c1");
    tick();
    @(negedge i_clock);
    set_quiet();
    #1 chk_stall("brload_c2", 1'b1);
    tick();
    @(negedge i_clock);
    #1 chk_stall("brload_done", 1'b0);
    chk_cnt("brload_done");

    // Flush in the second cycle of the branch stall.
    @(negedge i_clock);
    drive(br_load);
    #1 chk_stall("flush_c1", 1'b1);
    tick();
    @(negedge i_clock);
    set_quiet();
    i_flush = 1'b1;
    #1 chk_stall("flush_c2", 1'b0);
    @(negedge i_clock);
    i_flush = 1'b0;
    drive(load_use);
    #1 chk_stall("flush_idle", 1'b1);
    chk_cnt("flush_idle");
    tick();

    // Long run of stalls: the 4-bit counter must saturate at 15.
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      drive(load_use);
      #1 chk_stall($sformatf("sat%0d", i), 1'b1);
      tick();
    end
    @(negedge i_clock);
    set_quiet();
    #1 chk_cnt("sat_end");
    chk({"sat_small_15"}, {28'd0, s_stall_cycles}, 32'd15);

    // Reset in the middle of a STALL.
    @(negedge i_clock);
    drive(br_load);
    #1 chk_stall("rst_c1", 1'b1);
    @(negedge i_clock);
    set_quiet();
    #1 chk_stall("rst_c2", 1'b1);
    i_reset = 1'b0;
    #1 chk_stall("rst_async", 1'b0);
    exp_cnt = 0;
    exp_small = 0;
    chk_cnt("rst_async");
    @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
    #1 chk_stall("rst_after", 1'b0);
    chk_cnt("rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised hazard detection unit for the five-stage pipeline. It sits in the ID stage and compares the decoded source registers against pending writes in EX and MEM. It generates multi-cycle stalls for load-use hazards and for jumps/branches that resolve in ID. A small FSM holds the stall for the required number of cycles, and a saturating counter tracks total stall cycles for the debug unit.

## Interface
- NB_REG_ADDR, 5, register address width
- NB_STALL_CNT, 2, width of internal remaining-stall counter (max stall = 2^NB_STALL_CNT − 1)
- NB_PERF_CNT, 32, width of stall-cycle performance counter
- i_clock  in  1  pipeline clock, rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_valid_id  in  1  ID holds a real instruction (not a bubble)
- i_rs  in  NB_REG_ADDR  ID source register rs
- i_rt  in  NB_REG_ADDR  ID source register rt
- i_use_rs  in  1  ID instruction reads rs
- i_use_rt  in  1  ID instruction reads rt
- i_jmp_branch  in  1  ID instruction is a branch or jump-register (operands consumed in ID)
- i_ex_regwrite  in  1  EX instruction writes a register
- i_ex_mem_read  in  1  EX instruction is a load
- i_ex_rd  in  NB_REG_ADDR  EX destination register
- i_mem_mem_read  in  1  MEM instruction is a load
- i_mem_rd  in  NB_REG_ADDR  MEM destination register
- i_flush  in  1  pipeline flush from a later stage; aborts any stall
- o_stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- o_hazard  out  1  identical to o_stall, kept for existing top-level hookup
- o_stall_cycles  out  NB_PERF_CNT  registered count of cycles with o_stall high

## Operation
- Match on a source: src_x = i_use_x & (i_x == dest) & (dest != 0). Register 0 never causes a hazard.
- Required stall count `need`, computed combinationally. It is 0 if i_valid_id is low. Otherwise it is the maximum of the following:
  - EX load matching a source: need = 1 for a non-branch instruction, need = 2 if i_jmp_branch.
  - EX non-load with i_ex_regwrite matching a source, and i_jmp_branch high: need = 1.
  - MEM load matching a source, and i_jmp_branch high: need = 1.
  - MEM non-load: 0, because forwarding covers it.
- FSM states: IDLE and STALL. Remaining counter is `rem` (NB_STALL_CNT bits).
  - IDLE, need == 0: o_stall = 0; stay IDLE.
  - IDLE, need == 1: o_stall = 1; stay IDLE. Inputs are re-evaluated next cycle.
  - IDLE, need ≥ 2: o_stall = 1; rem ← need − 2; go to STALL.
  - STALL: o_stall = 1 regardless of inputs. If rem == 0, go to IDLE; otherwise rem ← rem − 1.
  - i_flush high, any state: o_stall = 0 this cycle; next state IDLE, rem ← 0. Flush has priority over detection.
- o_hazard = o_stall.
- Performance counter: o_stall_cycles ← o_stall_cycles + 1 on each cycle o_stall is high. It saturates at all-ones with no wrap.

## Timing
- Reset (i_reset low, asynchronous) forces:
  - state IDLE, rem = 0, o_stall_cycles = 0
  - o_stall = o_hazard = 0, provided inputs give need == 0
- o_stall is combinational from the ID/EX/MEM inputs in IDLE, and has zero latency from the hazard appearing.
- In STALL, o_stall depends only on the registered state.
- Total stall length equals `need` evaluated in the first cycle. A new hazard seen during STALL is ignored until the return to IDLE, then evaluated fresh.
- o_stall_cycles lags o_stall by one cycle.
- Reset asserted mid-STALL clears the state immediately. o_stall drops asynchronously unless the inputs give need > 0.

## Test plan
- Load-use: EX load, i_ex_rd = 5; ID add with i_rs = 5, i_use_rs = 1 -> o_stall high for exactly 1 cycle; o_stall_cycles = 1 one cycle later.
- Branch after load: EX load, i_ex_rd = 3; ID beq with i_rt = 3, i_jmp_branch = 1 -> o_stall high 2 consecutive cycles, FSM passes through STALL, o_stall_cycles = 2.
- Register zero and unused operands: EX load, i_ex_rd = 0 with i_rs = 0; then i_ex_rd = 7 with i_rt = 7 and i_use_rt = 0 -> o_stall stays 0 in both cases.
- Branch after ALU op and after a MEM load: EX regwrite with i_ex_rd = 9 and ID jr with i_rs = 9 -> 1-cycle stall. MEM load with i_mem_rd = 9, same jr -> 1-cycle stall. Non-branch add against MEM load rd = 9 -> no stall.
- Flush mid-stall: start the 2-cycle branch stall, assert i_flush in cycle 2 -> o_stall = 0 that cycle, FSM IDLE next cycle, o_stall_cycles = 1.
- Reset and saturation: preload the counter near max with NB_PERF_CNT = 4 and stall 20 cycles -> holds at 15. Pull i_reset low mid-STALL -> counter 0 and o_stall 0 immediately.
